alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//   Shares one combinational 8-bit ALU (a, b, 2-bit op -> y, ovf) between two requesters.
//   Round-robin arbitration, valid/ready handshakes on both requests and on the single
//   response channel. Runs one operation at a time; operands are registered while the ALU settles.
//   Sits between the requester blocks and the shared ALU instance.
// PARAMETERS
//   W           8   operand/result width
//   OPW         2   ALU opcode width; opcode passed through unmodified
//   EXEC_CYCLES 1   cycles operands are held on the ALU before the result is sampled (>=1)
// PORTS
//   clk         in   1    single clock, rising edge
//   rst_n       in   1    synchronous, active-low reset
//   req0_valid  in   1    requester 0 has an operation
//   req0_ready  out  1    requester 0 operation accepted this cycle
//   req0_a      in   W    operand a
//   req0_b      in   W    operand b
//   req0_op     in   OPW  ALU opcode
//   req1_*      --   --   same set as req0_* for requester 1
//   alu_a       out  W    registered operand a to ALU
//   alu_b       out  W    registered operand b to ALU
//   alu_op      out  OPW  registered opcode to ALU
//   alu_y       in   W    ALU result
//   alu_ovf     in   1    ALU overflow flag
//   rsp_valid   out  1    response available
//   rsp_ready   in   1    consumer takes response
//   rsp_id      out  1    requester that issued the operation
//   rsp_y       out  W    captured result
//   rsp_ovf     out  1    captured overflow
// BEHAVIOUR
//   Reset (rst_n=0 at a rising edge): state=IDLE, all registered outputs 0, priority to req0.
//   Reset mid-operation drops the transaction; no response is issued.
//   FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE
//   - reqN_ready is combinational: high only in IDLE for the granted requester.
//   - Grant: if one valid, grant it. If both valid, grant the one that was not granted last
//     (req0 after reset).
//   - On a handshake, alu_a/alu_b/alu_op/rsp_id are loaded, exec counter is cleared,
//     and the FSM goes to EXEC.
//   - Both readys are never high in the same cycle.
//   EXEC
//   - alu_* stays stable; the counter increments each cycle.
//   - On cycle EXEC_CYCLES: rsp_y<=alu_y, rsp_ovf<=alu_ovf, rsp_valid<=1, go RESP.
//   RESP
//   - rsp_* is held stable while rsp_valid && !rsp_ready.
//   - On rsp_ready: rsp_valid<=0, last-grant pointer <= rsp_id, go IDLE.
//   - No reqN_ready is asserted outside IDLE.
//   - alu_* holds its last value in IDLE and RESP.
//   Latency: handshake in cycle T -> rsp_valid high from cycle T+EXEC_CYCLES+1.
//   Throughput: max 1 op per EXEC_CYCLES+2 cycles (rsp_ready tied high).
//   Widths: no arithmetic in this block; y/ovf are captured verbatim. Counter is
//   clog2(EXEC_CYCLES+1) bits.
//   A requester dropping valid before it receives ready is legal; there is no stickiness.
// TESTING
//   1. req0 a=0x2B b=0x1E op=00, rsp_ready=1, EXEC_CYCLES=1 -> req0_ready 1 cycle;
//      rsp_valid at T+2, rsp_id=0, rsp_y=0x49, rsp_ovf=0.
//   2. Both valid continuously after reset -> grants 0,1,0,1; rsp_id alternates;
//      readys never overlap.
//   3. req1 a=0x4B b=0x85 op=01 (sub) -> rsp_id=1, rsp_y=0xC6, rsp_ovf=1.
//   4. rsp_ready low for 5 cycles in RESP -> rsp_* stable, both readys 0;
//      release -> IDLE next cycle.
//   5. rst_n=0 during EXEC -> next cycle all outputs 0, rsp_valid never rises;
//      req0 then wins a simultaneous request.
//   6. EXEC_CYCLES=3, single req0 -> alu_* stable 3 cycles; rsp_valid at T+4.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU between two valid/ready requesters
//   clk, rst_n                         : clock, synchronous active-low reset
//   req{0,1}_valid/ready/a/b/op        : request channels, ready is combinational in IDLE
//   alu_a, alu_b, alu_op / alu_y, alu_ovf : registered operands to the ALU / its result
//   rsp_valid, rsp_ready, rsp_id, rsp_y, rsp_ovf : response channel
module alu_rr_scheduler #(
    parameter int W           = 8,
    parameter int OPW         = 2,
    parameter int EXEC_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_ovf,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_y,
    output logic           rsp_ovf
);
    localparam int CW = $clog2(EXEC_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          last, sel, done;
    // last resets to 1 so that req0 wins the first contested grant
    always_comb begin
        state_next = state;
        sel        = (req0_valid && req1_valid) ? !last : req1_valid;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !sel;
                req1_ready = req1_valid && sel;
                if (req0_valid || req1_valid) state_next = EXEC;
            end
            EXEC: begin
                done = (cnt == CW'(EXEC_CYCLES - 1));
                if (done) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            rsp_id  <= 1'b0;
            rsp_y   <= '0;
            rsp_ovf <= 1'b0;
            cnt     <= '0;
            last    <= 1'b1;
        end else begin
            if (state == IDLE && (req0_valid || req1_valid)) begin
                alu_a  <= sel ? req1_a  : req0_a;
                alu_b  <= sel ? req1_b  : req0_b;
                alu_op <= sel ? req1_op : req0_op;
                rsp_id <= sel;
                cnt    <= '0;
            end
            if (state == EXEC) cnt <= cnt + CW'(1);
            if (done) begin
                rsp_y   <= alu_y;
                rsp_ovf <= alu_ovf;
            end
            if (rsp_valid && rsp_ready) last <= rsp_id;
        end
    end
endmodule
